// File: rtl/boot_loader.sv
// Byte-stream program loader: receives a length-prefixed little-endian image, writes it word by word
// into instruction memory and holds the CPU in reset until done. BOOT_CHECKSUM_EN adds an XOR trailer check.
module boot_loader #(
    parameter int ADDR_W    = 7,
    parameter int MAX_WORDS = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
`ifdef BOOT_CHECKSUM_EN
      , ST_CHK    = 3'd6
`endif
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            take_s;
    logic            len_bad_s;
    logic            last_s;
    logic            word_full_s;
    logic [15:0]     len_full_s;
    logic [ADDR_W:0] idx_inc_s;
    logic [7:0]      len_lo_r;
    logic [ADDR_W:0] len_r;
    logic [ADDR_W:0] idx_r;
    logic [1:0]      bcnt_r;
    logic [23:0]     asm_r;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]      xor_r;
`endif

    // Ready is a pure decode of the registered state
    always_comb begin
        in_ready = 1'b0;
        case (state_r)
            ST_LEN_LO: in_ready = 1'b1;
            ST_LEN_HI: in_ready = 1'b1;
            ST_DATA:   in_ready = 1'b1;
`ifdef BOOT_CHECKSUM_EN
            ST_CHK:    in_ready = 1'b1;
`endif
            default:   in_ready = 1'b0;
        endcase
    end

    // Handshake, length validity and word-boundary decode
    always_comb begin
        take_s      = in_valid && in_ready;
        len_full_s  = {in_byte, len_lo_r};
        len_bad_s   = (len_full_s == 16'd0) || (len_full_s > MAX_LEN);
        idx_inc_s   = idx_r + {{ADDR_W{1'b0}}, 1'b1};
        last_s      = (idx_inc_s == len_r);
        word_full_s = take_s && (state_r == ST_DATA) && (bcnt_r == 2'd3);
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_LEN_LO: begin
                if (take_s) state_s = ST_LEN_HI;
                else        state_s = state_r;
            end
            ST_LEN_HI: begin
                if (take_s && len_bad_s)  state_s = ST_ERR;
                else if (take_s)          state_s = ST_DATA;
                else                      state_s = state_r;
            end
            ST_DATA: begin
                if (word_full_s) state_s = ST_WRITE;
                else             state_s = state_r;
            end
            ST_WRITE: begin
`ifdef BOOT_CHECKSUM_EN
                if (last_s) state_s = ST_CHK;
`else
                if (last_s) state_s = ST_DONE;
`endif
                else        state_s = ST_DATA;
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CHK: begin
                if (take_s && (in_byte == xor_r)) state_s = ST_DONE;
                else if (take_s)                  state_s = ST_ERR;
                else                              state_s = state_r;
            end
`endif
            ST_DONE: state_s = ST_DONE;
            ST_ERR:  state_s = ST_ERR;
            // Unreachable encodings fail safe: CPU stays held
            default: state_s = ST_ERR;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_r <= ST_LEN_LO;
        else      state_r <= state_s;
    end

    // Length capture, word assembly and word index
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_lo_r <= 8'd0;
            len_r    <= {(ADDR_W+1){1'b0}};
            idx_r    <= {(ADDR_W+1){1'b0}};
            bcnt_r   <= 2'd0;
            asm_r    <= 24'd0;
`ifdef BOOT_CHECKSUM_EN
            xor_r    <= 8'd0;
`endif
        end else begin
            if (take_s && (state_r == ST_LEN_LO)) len_lo_r <= in_byte;
            // Length is range-checked before use, so ADDR_W+1 bits always hold it
            if (take_s && (state_r == ST_LEN_HI)) begin
                len_r  <= len_full_s[ADDR_W:0];
                idx_r  <= {(ADDR_W+1){1'b0}};
                bcnt_r <= 2'd0;
            end
            if (take_s && (state_r == ST_DATA)) begin
                bcnt_r <= bcnt_r + 2'd1;
                case (bcnt_r)
                    2'd0:    asm_r[7:0]   <= in_byte;
                    2'd1:    asm_r[15:8]  <= in_byte;
                    2'd2:    asm_r[23:16] <= in_byte;
                    default: asm_r        <= asm_r;
                endcase
`ifdef BOOT_CHECKSUM_EN
                xor_r <= xor_r ^ in_byte;
`endif
            end
            if (state_r == ST_WRITE) idx_r <= idx_inc_s;
        end
    end

    // Registered outputs, derived from the state being entered
    always_ff @(posedge clk) begin
        if (!rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= {ADDR_W{1'b0}};
            imem_wdata <= 32'd0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we  <= (state_s == ST_WRITE);
            cpu_hold <= (state_s != ST_DONE);
            done     <= (state_s == ST_DONE);
            err      <= (state_s == ST_ERR);
            // The 4th byte goes straight into the top lane of the written word
            if (word_full_s) begin
                imem_addr  <= idx_r[ADDR_W-1:0];
                imem_wdata <= {in_byte, asm_r};
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: scoreboard of expected memory writes plus a length-vector table
// and hand-written sequences for latency, max image, reset abort and checksum.
module tb_boot_loader;

    localparam int ADDR_W    = 7;
    localparam int MAX_WORDS = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        int         nwords;
        bit         gaps;
        bit         bad;
    } vec_t;

    int                 checks   = 0;
    int                 failures = 0;
    int                 writes   = 0;
    logic [ADDR_W+31:0] sb[$];
    logic [ADDR_W-1:0]  exp_addr;
    logic [7:0]         run_xor;
    vec_t               vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every observed write must match the oldest expected one
    always @(negedge clk) begin
        logic [ADDR_W+31:0] e;
        if (imem_we === 1'b1) begin
            writes++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=addr %0d data %h required=no write", imem_addr, imem_wdata);
            end else begin
                e = sb.pop_front();
                check("write", 64'({imem_addr, imem_wdata}), 64'(e));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc = 1'b0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_byte  = b;
        for (int c = 0; c < 16 && !acc; c++) begin
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL byte_accept actual=timeout required=accepted byte=%h", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        sb.push_back({exp_addr, w});
        exp_addr++;
        for (int k = 0; k < 4; k++) begin
            run_xor ^= w[8*k +: 8];
            send_byte(w[8*k +: 8], gaps);
        end
    endtask

    task automatic start_image(input logic [7:0] lo, input logic [7:0] hi, input bit gaps);
        exp_addr = '0;
        run_xor  = 8'h00;
        writes   = 0;
        send_byte(lo, gaps);
        send_byte(hi, gaps);
    endtask

    task automatic finish_image(input bit gaps);
`ifdef BOOT_CHECKSUM_EN
        send_byte(run_xor, gaps);
`else
        if (gaps) begin @(posedge clk); #1; end
`endif
    endtask

    task automatic wait_end();
        for (int c = 0; c < 12 && !(done || err); c++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst      = 1'b1;
        writes   = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{lo: 8'h03, hi: 8'h00, nwords: 3, gaps: 1'b0, bad: 1'b0};
        vecs[1] = '{lo: 8'h00, hi: 8'h00, nwords: 0, gaps: 1'b0, bad: 1'b1};
        vecs[2] = '{lo: 8'h81, hi: 8'h00, nwords: 0, gaps: 1'b0, bad: 1'b1};
        vecs[3] = '{lo: 8'h01, hi: 8'h01, nwords: 0, gaps: 1'b1, bad: 1'b1};
        vecs[4] = '{lo: 8'h05, hi: 8'h00, nwords: 5, gaps: 1'b1, bad: 1'b0};

        rst = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        exp_addr = '0; run_xor = 8'h00;

        // Reset values
        repeat (3) begin @(posedge clk); #1; end
        check("rst_hold", 64'(cpu_hold), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_we", 64'(imem_we), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_wdata", 64'(imem_wdata), 64'd0);
        rst = 1'b1;
        check("rst_ready", 64'(in_ready), 64'd1);

        // Single word: write strobe right after the 4th byte, done one cycle after the write
        start_image(8'h01, 8'h00, 1'b0);
        send_word(32'h0050_0513, 1'b0);
        check("lat_we", 64'(imem_we), 64'd1);
        check("lat_addr", 64'(imem_addr), 64'd0);
        check("lat_data", 64'(imem_wdata), 64'h0050_0513);
        check("lat_ready", 64'(in_ready), 64'd0);
        check("lat_hold", 64'(cpu_hold), 64'd1);
`ifdef BOOT_CHECKSUM_EN
        check("lat_xor", 64'(run_xor), 64'h46);
        send_byte(8'h46, 1'b0);
`else
        @(posedge clk); #1;
`endif
        check("one_done", 64'(done), 64'd1);
        check("one_hold", 64'(cpu_hold), 64'd0);
        check("one_we", 64'(imem_we), 64'd0);
        check("one_writes", 64'(writes), 64'd1);

        // Length vector table
        for (int v = 0; v < 5; v++) begin
            do_reset();
            start_image(vecs[v].lo, vecs[v].hi, vecs[v].gaps);
            if (!vecs[v].bad) begin
                for (int i = 0; i < vecs[v].nwords; i++) send_word($urandom, vecs[v].gaps);
                finish_image(vecs[v].gaps);
            end
            wait_end();
            repeat (2) begin @(posedge clk); #1; end
            check($sformatf("vec%0d_err", v), 64'(err), 64'(vecs[v].bad));
            check($sformatf("vec%0d_done", v), 64'(done), 64'(!vecs[v].bad));
            check($sformatf("vec%0d_hold", v), 64'(cpu_hold), 64'(vecs[v].bad));
            check($sformatf("vec%0d_ready", v), 64'(in_ready), 64'd0);
            check($sformatf("vec%0d_writes", v), 64'(writes), 64'(vecs[v].nwords));
        end

        // Max image with random gaps, word i = i
        do_reset();
        start_image(8'h80, 8'h00, 1'b1);
        for (int i = 0; i < 128; i++) send_word(32'(i), 1'b1);
        finish_image(1'b1);
        wait_end();
        check("max_done", 64'(done), 64'd1);
        check("max_err", 64'(err), 64'd0);
        check("max_writes", 64'(writes), 64'd128);
        check("max_sb_empty", 64'(sb.size()), 64'd0);
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        repeat (4) begin @(posedge clk); #1; end
        check("max_extra_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        check("max_extra_writes", 64'(writes), 64'd128);
        check("max_still_done", 64'(done), 64'd1);

        // Reset mid-load after 6 data bytes of an N=4 image
        do_reset();
        start_image(8'h04, 8'h00, 1'b0);
        send_word(32'hCAFE_F00D, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ready", 64'(in_ready), 64'd1);
        check("abort_we", 64'(imem_we), 64'd0);
        check("abort_hold", 64'(cpu_hold), 64'd1);
        rst = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check("abort_writes", 64'(writes), 64'd1);
        start_image(8'h01, 8'h00, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        finish_image(1'b0);
        wait_end();
        check("reload_done", 64'(done), 64'd1);
        check("reload_writes", 64'(writes), 64'd1);

`ifdef BOOT_CHECKSUM_EN
        // Checksum match and mismatch
        do_reset();
        start_image(8'h01, 8'h00, 1'b0);
        send_word(32'h4433_2211, 1'b0);
        send_byte(8'h44, 1'b0);
        wait_end();
        check("chk_ok_done", 64'(done), 64'd1);
        check("chk_ok_err", 64'(err), 64'd0);
        do_reset();
        start_image(8'h01, 8'h00, 1'b0);
        send_word(32'h4433_2211, 1'b0);
        send_byte(8'h45, 1'b0);
        wait_end();
        check("chk_bad_err", 64'(err), 64'd1);
        check("chk_bad_hold", 64'(cpu_hold), 64'd1);
        check("chk_bad_writes", 64'(writes), 64'd1);
`endif

        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Program loader between the external byte link and the core's instruction memory. After reset it holds the CPU in reset, receives a length-prefixed little-endian program image one byte at a time, writes each assembled 32-bit word into `instr_mem` starting at word 0, and releases the CPU once the last word is written. In hardware it replaces the bench-only memory preload.

## Interface

Parameters:
- `ADDR_W`, 7: instruction-memory word-address width; 128 words = 512 bytes.
- `MAX_WORDS`, 128: largest accepted image in words; must be ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  `in_byte` holds a valid byte.
- `in_byte`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  one-cycle write strobe to instruction memory.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  word to write.
- `cpu_hold`  out  1  1 = keep CPU in reset.
- `done`  out  1  image loaded; sticky.
- `err`  out  1  bad length or checksum; sticky.

## Operation

- States: LEN_LO, LEN_HI, DATA, WRITE, (CHK), DONE, ERR.
- Transfer: a byte is taken on a rising edge where `in_valid && in_ready`. `in_valid` without `in_ready` is held off and no byte is lost.
- LEN_LO/LEN_HI: capture a 16-bit word count N, low byte first.
  - N == 0 or N > MAX_WORDS goes to ERR.
  - Otherwise go to DATA.
- DATA: shift bytes into a 32-bit assembler, little-endian. Byte k of a word lands in bits [8k+7:8k]. After the 4th byte, go to WRITE.
- WRITE: one cycle. `imem_we=1`, `imem_addr` = word index, `imem_wdata` = assembled word. The word index then increments.
  - If the index has reached N: go to DONE (macro off) or CHK (macro on).
  - Otherwise return to DATA.
- DONE: `cpu_hold=0`, `done=1`. Extra input bytes are not accepted.
- ERR: `cpu_hold=1`, `err=1`.
- DONE and ERR are left only by reset.
- Word index width is ADDR_W+1 bits so that N = MAX_WORDS is reachable without wrap. Addresses are written strictly from 0 to N-1. Words at N and above are untouched.

## Timing

- Values during and immediately after reset:
  - `imem_we=0`, `imem_addr=0`, `imem_wdata=0`
  - `cpu_hold=1`, `done=0`, `err=0`
  - state LEN_LO, so `in_ready=1` in the first cycle after `rst` rises.
- `in_ready` is 1 in LEN_LO, LEN_HI, DATA and CHK. It is 0 in WRITE, DONE and ERR. It is a combinational decode of the registered state.
- All other outputs are registered.
- Throughput: the first and later words each take 4 accepted bytes plus 1 WRITE cycle, so a continuous stream runs at 5 cycles per word.
- Latency from the edge accepting a word's 4th byte: `imem_we` is high during the next cycle.
- After the last WRITE (macro off), `cpu_hold` falls and `done` rises in the following cycle. The CPU's first fetch therefore sees fully written memory.
- Reset asserted mid-load aborts immediately at the next edge. State returns to LEN_LO with all outputs at reset values. Memory already written is left as is; the next image overwrites it.
- `in_valid` may drop between bytes; the partial word is kept.

## Configuration

- `BOOT_CHECKSUM_EN` defined:
  - After the last WRITE, the state goes to CHK and accepts one trailer byte.
  - That byte must equal the XOR of all 4·N data bytes. Length bytes are excluded.
  - Match goes to DONE, mismatch to ERR.
  - The running XOR register resets to 0.
- Macro undefined: no CHK state, no XOR register, no trailer byte. The state goes from the last WRITE straight to DONE.

## Test plan

- Reset values: hold `rst=0` for 3 cycles. During reset `cpu_hold=1`, `done=0`, `err=0`, `imem_we=0`. After release, `in_ready=1`.
- Single word: send 01 00 13 05 50 00 (plus trailer 46 if the macro is on). Exactly one `imem_we` pulse occurs, with addr 0 and data 0x00500513. `done` and `!cpu_hold` follow one cycle later.
- Max image and gaps: N=128 (80 00), word i = i, `in_valid` toggled randomly. 128 writes occur at addresses 0..127 with matching data. No extra write and no address wrap. `done=1`.
- Bad length: send 00 00 → `err=1`, `in_ready=0`, `cpu_hold=1`, no write. Separately send 81 00 → same result.
- Reset mid-load: reset after 6 data bytes of an N=4 image. No further writes occur and the state returns to LEN_LO. A fresh N=1 image then loads normally at address 0.
- Checksum (macro on): N=1, data 11 22 33 44, trailer 44 → `done`. The same image with trailer 45 → `err` with `cpu_hold=1`. The word is still written.
